// File: rtl/vta_host_req_bridge.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | vta_host_req_bridge: host register-request FIFO with read credits,        |
// | response timeout and free-running cycle counter.        Rev 1.0           |
// +---------------------------------------------------------------------------+
module vta_host_req_bridge #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 32,
  parameter int DEPTH          = 4,
  parameter int MAX_RD         = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 host_req_valid,
  output logic                 host_req_ready,
  input  logic                 host_req_opcode,
  input  logic [ADDR_BITS-1:0] host_req_addr,
  input  logic [DATA_BITS-1:0] host_req_value,
  output logic                 dpi_req_valid,
  output logic                 dpi_req_opcode,
  output logic [ADDR_BITS-1:0] dpi_req_addr,
  output logic [DATA_BITS-1:0] dpi_req_value,
  input  logic                 dpi_req_deq,
  input  logic                 dpi_resp_valid,
  input  logic [DATA_BITS-1:0] dpi_resp_bits,
  output logic                 host_resp_valid,
  output logic [DATA_BITS-1:0] host_resp_bits,
  output logic                 host_resp_err,
  output logic                 busy,
  output logic [63:0]          cycles
);

  localparam int PTR_BITS   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS   = PTR_BITS + 1;
  localparam int RD_BITS    = $clog2(MAX_RD + 1);
  localparam int TMR_BITS   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int ENTRY_BITS = 1 + ADDR_BITS + DATA_BITS;

  localparam logic [CNT_BITS-1:0] DEPTH_C  = CNT_BITS'(DEPTH);
  localparam logic [RD_BITS-1:0]  MAX_RD_C = RD_BITS'(MAX_RD);
  localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    WAIT_RD = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ENTRY_BITS-1:0] mem [DEPTH];
  logic [ENTRY_BITS-1:0] head;
  logic [PTR_BITS-1:0]   wr_ptr;
  logic [PTR_BITS-1:0]   rd_ptr;
  logic [CNT_BITS-1:0]   count;
  logic [RD_BITS-1:0]    rd_pending;
  logic [TMR_BITS-1:0]   timer;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head_is_read;
  logic credit_exhausted;
  logic rd_inc;
  logic rd_dec;
  logic resp_accept;
  logic timeout_hit;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  assign head_is_read     = ~head[ENTRY_BITS-1];
  assign credit_exhausted = (rd_pending == MAX_RD_C);

  assign host_req_ready = ~full;
  assign push           = host_req_valid & ~full;

  // A read at the head stalls while all read credits are in use.
  assign dpi_req_valid = ~empty & ~(head_is_read & credit_exhausted);
  assign pop           = dpi_req_valid & dpi_req_deq;

  // Head fields are masked while empty so outputs stay defined after reset.
  assign dpi_req_opcode = empty ? 1'b0 : head[ENTRY_BITS-1];
  assign dpi_req_addr   = empty ? '0 : head[ENTRY_BITS-2 -: ADDR_BITS];
  assign dpi_req_value  = empty ? '0 : head[DATA_BITS-1:0];

  assign resp_accept = dpi_resp_valid & (rd_pending != '0);
  assign timeout_hit = (rd_pending != '0) & (timer == TMR_LAST) & ~resp_accept;

  assign rd_inc = pop & head_is_read;
  assign rd_dec = resp_accept | timeout_hit;

  assign busy = ~empty | (rd_pending != '0);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {host_req_opcode, host_req_addr, host_req_value};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_pending <= '0;
      timer      <= '0;
    end else begin
      rd_pending <= rd_pending + RD_BITS'(rd_inc) - RD_BITS'(rd_dec);
      if ((rd_pending == '0) || resp_accept || timeout_hit) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Real responses and timeout retirements share one registered response port.
  always_ff @(posedge clock) begin
    if (!reset) begin
      host_resp_valid <= 1'b0;
      host_resp_bits  <= '0;
      host_resp_err   <= 1'b0;
    end else begin
      host_resp_valid <= resp_accept | timeout_hit;
      host_resp_bits  <= resp_accept ? dpi_resp_bits : '0;
      host_resp_err   <= timeout_hit;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cycles <= 64'd0;
    end else begin
      cycles <= cycles + 64'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (timeout_hit) begin
      state_next = TIMEOUT;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state_next = ACTIVE;
          end
        end
        ACTIVE: begin
          if (empty && (rd_pending != '0)) begin
            state_next = WAIT_RD;
          end else if (empty) begin
            state_next = IDLE;
          end
        end
        WAIT_RD: begin
          if (!empty) begin
            state_next = ACTIVE;
          end else if (rd_pending == '0) begin
            state_next = IDLE;
          end
        end
        TIMEOUT: begin
          if (!empty) begin
            state_next = ACTIVE;
          end else if (rd_pending != '0) begin
            state_next = WAIT_RD;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vta_host_req_bridge.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_vta_host_req_bridge: scenario bench with request/response scoreboards. |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_vta_host_req_bridge;

  localparam int ADDR_BITS      = 8;
  localparam int DATA_BITS      = 32;
  localparam int DEPTH          = 4;
  localparam int MAX_RD         = 2;
  localparam int TIMEOUT_CYCLES = 16;

  typedef struct packed {
    logic                 op;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] value;
  } req_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] bits;
    logic                 err;
  } resp_t;

  logic                 clock;
  logic                 reset;
  logic                 host_req_valid;
  logic                 host_req_ready;
  logic                 host_req_opcode;
  logic [ADDR_BITS-1:0] host_req_addr;
  logic [DATA_BITS-1:0] host_req_value;
  logic                 dpi_req_valid;
  logic                 dpi_req_opcode;
  logic [ADDR_BITS-1:0] dpi_req_addr;
  logic [DATA_BITS-1:0] dpi_req_value;
  logic                 dpi_req_deq;
  logic                 dpi_resp_valid;
  logic [DATA_BITS-1:0] dpi_resp_bits;
  logic                 host_resp_valid;
  logic [DATA_BITS-1:0] host_resp_bits;
  logic                 host_resp_err;
  logic                 busy;
  logic [63:0]          cycles;

  req_t  req_q[$];
  resp_t resp_q[$];
  int    tests_run;
  int    tests_failed;

  vta_host_req_bridge #(
    .ADDR_BITS      (ADDR_BITS),
    .DATA_BITS      (DATA_BITS),
    .DEPTH          (DEPTH),
    .MAX_RD         (MAX_RD),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .host_req_valid  (host_req_valid),
    .host_req_ready  (host_req_ready),
    .host_req_opcode (host_req_opcode),
    .host_req_addr   (host_req_addr),
    .host_req_value  (host_req_value),
    .dpi_req_valid   (dpi_req_valid),
    .dpi_req_opcode  (dpi_req_opcode),
    .dpi_req_addr    (dpi_req_addr),
    .dpi_req_value   (dpi_req_value),
    .dpi_req_deq     (dpi_req_deq),
    .dpi_resp_valid  (dpi_resp_valid),
    .dpi_resp_bits   (dpi_resp_bits),
    .host_resp_valid (host_resp_valid),
    .host_resp_bits  (host_resp_bits),
    .host_resp_err   (host_resp_err),
    .busy            (busy),
    .cycles          (cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    host_req_valid  = 1'b0;
    host_req_opcode = 1'b0;
    host_req_addr   = '0;
    host_req_value  = '0;
    dpi_req_deq     = 1'b0;
    dpi_resp_valid  = 1'b0;
    dpi_resp_bits   = '0;
  endtask

  // Drives one host request for a cycle; the model FIFO records it if there is room.
  task automatic host_push(input logic op, input logic [ADDR_BITS-1:0] addr,
                           input logic [DATA_BITS-1:0] value);
    req_t r;
    r.op = op;
    r.addr = addr;
    r.value = value;
    host_req_valid  = 1'b1;
    host_req_opcode = op;
    host_req_addr   = addr;
    host_req_value  = value;
    if (req_q.size() < DEPTH) req_q.push_back(r);
    step();
    host_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    tests_run++;
    if (host_req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b want 1", host_req_ready);
    end
    tests_run++;
    if ({dpi_req_valid, dpi_req_opcode, dpi_req_addr, dpi_req_value} !== '0) begin
      tests_failed++;
      $display("FAIL reset_dpi_req: got v=%b op=%b a=%h d=%h want all 0",
               dpi_req_valid, dpi_req_opcode, dpi_req_addr, dpi_req_value);
    end
    tests_run++;
    if ({host_resp_valid, host_resp_bits, host_resp_err, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_resp: got v=%b d=%h e=%b busy=%b want all 0",
               host_resp_valid, host_resp_bits, host_resp_err, busy);
    end
    tests_run++;
    if (cycles !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_cycles: got %0d want 0", cycles);
    end
    reset = 1'b1;
    step();
    step();
    step();
    tests_run++;
    if (cycles !== 64'd3) begin
      tests_failed++;
      $display("FAIL cycles_count: got %0d want 3", cycles);
    end
    req_q.delete();
    resp_q.delete();
  endtask

  task automatic test_write();
    req_t e;
    dpi_req_deq = 1'b1;
    host_push(1'b1, 8'h20, 32'hDEAD_BEEF);
    e = req_q[0];
    tests_run++;
    if (dpi_req_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_issue_valid: got %b want 1", dpi_req_valid);
    end
    tests_run++;
    if ({dpi_req_opcode, dpi_req_addr, dpi_req_value} !== {e.op, e.addr, e.value}) begin
      tests_failed++;
      $display("FAIL write_issue_fields: got op=%b a=%h d=%h want op=%b a=%h d=%h",
               dpi_req_opcode, dpi_req_addr, dpi_req_value, e.op, e.addr, e.value);
    end
    void'(req_q.pop_front());
    step();
    dpi_req_deq = 1'b0;
    tests_run++;
    if (dpi_req_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_drained: got valid=%b busy=%b want 0 0", dpi_req_valid, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (host_resp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL write_no_resp: got host_resp_valid=%b want 0 (cycle %0d)", host_resp_valid, i);
      end
      step();
    end
  endtask

  task automatic test_read();
    req_t  e;
    resp_t r;
    host_push(1'b0, 8'h04, 32'h0);
    e = req_q.pop_front();
    tests_run++;
    if (dpi_req_valid !== 1'b1 || dpi_req_opcode !== e.op || dpi_req_addr !== e.addr) begin
      tests_failed++;
      $display("FAIL read_issue: got v=%b op=%b a=%h want v=1 op=%b a=%h",
               dpi_req_valid, dpi_req_opcode, dpi_req_addr, e.op, e.addr);
    end
    dpi_req_deq = 1'b1;
    step();
    dpi_req_deq = 1'b0;
    tests_run++;
    if (dpi_req_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_pending: got valid=%b busy=%b want 0 1", dpi_req_valid, busy);
    end
    step();
    step();
    dpi_resp_valid = 1'b1;
    dpi_resp_bits  = 32'h0000_1234;
    resp_q.push_back('{bits: 32'h0000_1234, err: 1'b0});
    tests_run++;
    if (host_resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_latency: got host_resp_valid=%b want 0 before edge", host_resp_valid);
    end
    step();
    dpi_resp_valid = 1'b0;
    r = resp_q.pop_front();
    tests_run++;
    if (host_resp_valid !== 1'b1 || host_resp_bits !== r.bits || host_resp_err !== r.err) begin
      tests_failed++;
      $display("FAIL read_resp: got v=%b d=%h e=%b want v=1 d=%h e=%b",
               host_resp_valid, host_resp_bits, host_resp_err, r.bits, r.err);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_busy_fall: got %b want 0", busy);
    end
    step();
    tests_run++;
    if (host_resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_resp_pulse: got %b want 0", host_resp_valid);
    end
  endtask

  task automatic test_overflow();
    req_t e;
    int   n;
    dpi_req_deq = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      tests_run++;
      if (host_req_ready !== (req_q.size() < DEPTH)) begin
        tests_failed++;
        $display("FAIL ovf_ready: got %b want %b (push %0d)", host_req_ready, req_q.size() < DEPTH, i);
      end
      host_push(1'b1, ADDR_BITS'(i), 32'hC0DE_0000 + DATA_BITS'(i));
    end
    tests_run++;
    if (host_req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_full: got ready=%b want 0", host_req_ready);
    end
    dpi_req_deq = 1'b1;
    n = 0;
    while (req_q.size() > 0 && n < DEPTH + 2) begin
      e = req_q.pop_front();
      tests_run++;
      if (dpi_req_valid !== 1'b1 || dpi_req_addr !== e.addr || dpi_req_value !== e.value) begin
        tests_failed++;
        $display("FAIL ovf_drain: got v=%b a=%h d=%h want v=1 a=%h d=%h",
                 dpi_req_valid, dpi_req_addr, dpi_req_value, e.addr, e.value);
      end
      step();
      n++;
    end
    dpi_req_deq = 1'b0;
    tests_run++;
    if (dpi_req_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_empty: got valid=%b busy=%b want 0 0 (5th dropped)", dpi_req_valid, busy);
    end
  endtask

  task automatic test_credit();
    resp_t r;
    host_push(1'b0, 8'h10, 32'h0);
    host_push(1'b0, 8'h11, 32'h0);
    host_push(1'b0, 8'h12, 32'h0);
    dpi_req_deq = 1'b1;
    for (int i = 0; i < MAX_RD; i++) begin
      tests_run++;
      if (dpi_req_valid !== 1'b1 || dpi_req_addr !== req_q[0].addr) begin
        tests_failed++;
        $display("FAIL credit_issue: got v=%b a=%h want v=1 a=%h", dpi_req_valid, dpi_req_addr, req_q[0].addr);
      end
      void'(req_q.pop_front());
      step();
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (dpi_req_valid !== 1'b0 || dpi_req_addr !== req_q[0].addr) begin
        tests_failed++;
        $display("FAIL credit_stall: got v=%b a=%h want v=0 a=%h", dpi_req_valid, dpi_req_addr, req_q[0].addr);
      end
      step();
    end
    dpi_resp_valid = 1'b1;
    dpi_resp_bits  = 32'h0000_00A1;
    resp_q.push_back('{bits: 32'h0000_00A1, err: 1'b0});
    step();
    dpi_resp_valid = 1'b0;
    r = resp_q.pop_front();
    tests_run++;
    if (host_resp_valid !== 1'b1 || host_resp_bits !== r.bits || host_resp_err !== r.err) begin
      tests_failed++;
      $display("FAIL credit_resp: got v=%b d=%h e=%b want v=1 d=%h e=%b",
               host_resp_valid, host_resp_bits, host_resp_err, r.bits, r.err);
    end
    tests_run++;
    if (dpi_req_valid !== 1'b1 || dpi_req_addr !== req_q[0].addr) begin
      tests_failed++;
      $display("FAIL credit_release: got v=%b a=%h want v=1 a=%h", dpi_req_valid, dpi_req_addr, req_q[0].addr);
    end
    void'(req_q.pop_front());
    step();
    dpi_req_deq = 1'b0;
    for (int i = 0; i < MAX_RD; i++) begin
      dpi_resp_valid = 1'b1;
      dpi_resp_bits  = 32'h0000_00A2 + DATA_BITS'(i);
      resp_q.push_back('{bits: 32'h0000_00A2 + DATA_BITS'(i), err: 1'b0});
      step();
      dpi_resp_valid = 1'b0;
      r = resp_q.pop_front();
      tests_run++;
      if (host_resp_valid !== 1'b1 || host_resp_bits !== r.bits || host_resp_err !== r.err) begin
        tests_failed++;
        $display("FAIL credit_tail_resp: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                 host_resp_valid, host_resp_bits, host_resp_err, r.bits, r.err);
      end
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL credit_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    resp_t r;
    host_push(1'b0, 8'h40, 32'h0);
    host_push(1'b0, 8'h41, 32'h0);
    dpi_req_deq = 1'b1;
    void'(req_q.pop_front());
    step();
    dpi_resp_valid = 1'b1;
    dpi_resp_bits  = 32'h0000_00B0;
    resp_q.push_back('{bits: 32'h0000_00B0, err: 1'b0});
    tests_run++;
    if (dpi_req_valid !== 1'b1 || dpi_req_addr !== req_q[0].addr) begin
      tests_failed++;
      $display("FAIL b2b_issue: got v=%b a=%h want v=1 a=%h", dpi_req_valid, dpi_req_addr, req_q[0].addr);
    end
    void'(req_q.pop_front());
    step();
    dpi_req_deq    = 1'b0;
    dpi_resp_valid = 1'b0;
    r = resp_q.pop_front();
    tests_run++;
    if (host_resp_valid !== 1'b1 || host_resp_bits !== r.bits || host_resp_err !== r.err) begin
      tests_failed++;
      $display("FAIL b2b_resp0: got v=%b d=%h e=%b want v=1 d=%h e=%b",
               host_resp_valid, host_resp_bits, host_resp_err, r.bits, r.err);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_pending_kept: got busy=%b want 1", busy);
    end
    dpi_resp_valid = 1'b1;
    dpi_resp_bits  = 32'h0000_00B1;
    resp_q.push_back('{bits: 32'h0000_00B1, err: 1'b0});
    step();
    dpi_resp_valid = 1'b0;
    r = resp_q.pop_front();
    tests_run++;
    if (host_resp_valid !== 1'b1 || host_resp_bits !== r.bits || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_resp1: got v=%b d=%h busy=%b want v=1 d=%h busy=0",
               host_resp_valid, host_resp_bits, busy, r.bits);
    end
  endtask

  task automatic test_timeout();
    resp_t r;
    host_push(1'b0, 8'h30, 32'h0);
    void'(req_q.pop_front());
    dpi_req_deq = 1'b1;
    step();
    dpi_req_deq = 1'b0;
    resp_q.push_back('{bits: '0, err: 1'b1});
    for (int k = 1; k < TIMEOUT_CYCLES; k++) begin
      step();
      tests_run++;
      if (host_resp_valid !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL tmo_early: got v=%b busy=%b want 0 1 at cycle %0d", host_resp_valid, busy, k);
      end
    end
    step();
    r = resp_q.pop_front();
    tests_run++;
    if (host_resp_valid !== 1'b1 || host_resp_bits !== r.bits || host_resp_err !== r.err) begin
      tests_failed++;
      $display("FAIL tmo_retire: got v=%b d=%h e=%b want v=1 d=%h e=%b",
               host_resp_valid, host_resp_bits, host_resp_err, r.bits, r.err);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_busy: got %b want 0", busy);
    end
    dpi_resp_valid = 1'b1;
    dpi_resp_bits  = 32'h0000_0BAD;
    step();
    dpi_resp_valid = 1'b0;
    tests_run++;
    if (host_resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_late_drop: got host_resp_valid=%b want 0", host_resp_valid);
    end
    // A response landing on the last timer cycle wins over the timeout.
    host_push(1'b0, 8'h31, 32'h0);
    void'(req_q.pop_front());
    dpi_req_deq = 1'b1;
    step();
    dpi_req_deq = 1'b0;
    for (int k = 1; k < TIMEOUT_CYCLES; k++) step();
    dpi_resp_valid = 1'b1;
    dpi_resp_bits  = 32'h0000_5EED;
    resp_q.push_back('{bits: 32'h0000_5EED, err: 1'b0});
    step();
    dpi_resp_valid = 1'b0;
    r = resp_q.pop_front();
    tests_run++;
    if (host_resp_valid !== 1'b1 || host_resp_bits !== r.bits || host_resp_err !== r.err) begin
      tests_failed++;
      $display("FAIL tmo_resp_priority: got v=%b d=%h e=%b want v=1 d=%h e=%b",
               host_resp_valid, host_resp_bits, host_resp_err, r.bits, r.err);
    end
    step();
    tests_run++;
    if (host_resp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_suppressed: got v=%b busy=%b want 0 0", host_resp_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    host_push(1'b0, 8'h50, 32'h0);
    host_push(1'b0, 8'h51, 32'h0);
    host_push(1'b1, 8'h52, 32'h0000_0052);
    dpi_req_deq = 1'b1;
    step();
    step();
    dpi_req_deq = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || dpi_req_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got busy=%b valid=%b want 1 1", busy, dpi_req_valid);
    end
    reset = 1'b0;
    step();
    req_q.delete();
    tests_run++;
    if (cycles !== 64'd0 || busy !== 1'b0 || dpi_req_valid !== 1'b0 || host_req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_clear: got cycles=%0d busy=%b valid=%b ready=%b want 0 0 0 1",
               cycles, busy, dpi_req_valid, host_req_ready);
    end
    reset = 1'b1;
    dpi_resp_valid = 1'b1;
    dpi_resp_bits  = 32'h0000_00FF;
    step();
    dpi_resp_valid = 1'b0;
    step();
    tests_run++;
    if (host_resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_late_resp: got host_resp_valid=%b want 0", host_resp_valid);
    end
    tests_run++;
    if (cycles !== 64'd2) begin
      tests_failed++;
      $display("FAIL rst_mid_cycles: got %0d want 2", cycles);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no completion want completion");
    $fatal(1);
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_overflow();
    test_credit();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
